// File: rtl/mac_accum_unsigned_pkg.sv
// Shared unsigned fixed-point helpers: width math, MAC state encoding and
// a Q-format resize with fraction truncation and integer saturation.
package mac_accum_unsigned_pkg;

    localparam int FXP_MAXW = 128;

    typedef enum logic [0:0] {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    typedef struct packed {
        logic                ovf;
        logic [FXP_MAXW-1:0] data;
    } fxp_res_t;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Value is Q(wi_in.wf_in) right-aligned in FXP_MAXW bits; the result is
    // Q(wi_out.wf_out) right-aligned, all ones when the integer part does not fit.
    function automatic fxp_res_t fxp_resize_sat(input logic [FXP_MAXW-1:0] val,
                                                input int wi_in, input int wf_in,
                                                input int wi_out, input int wf_out);
        logic [FXP_MAXW-1:0] frac_al;
        logic [FXP_MAXW-1:0] ipart;
        logic [FXP_MAXW-1:0] mask;
        fxp_res_t            r;
        mask  = (FXP_MAXW'(1) << (wi_out + wf_out)) - FXP_MAXW'(1);
        ipart = val >> wf_in;
        if (wf_out >= wf_in) frac_al = val << (wf_out - wf_in);
        else                 frac_al = val >> (wf_in - wf_out);
        r.ovf  = (ipart >> wi_out) != '0;
        r.data = r.ovf ? mask : (frac_al & mask);
        return r;
    endfunction

endpackage

// File: rtl/fxp_resize_sat_unsigned.sv
// Combinational unsigned Q-format resize: truncate/pad fraction, saturate integer.
module fxp_resize_sat_unsigned
    import mac_accum_unsigned_pkg::*;
#(
    parameter int WII = 6,
    parameter int WIF = 46,
    parameter int WOI = 8,
    parameter int WOF = 24
) (
    input  logic [WII+WIF-1:0] din,
    output logic [WOI+WOF-1:0] dout,
    output logic               ovf
);

    localparam int WO = WOI + WOF;

    fxp_res_t              res;
    logic [FXP_MAXW-WO-1:0] unused_hi;

    always_comb begin
        res = fxp_resize_sat(FXP_MAXW'(din), WII, WIF, WOI, WOF);
    end

    assign dout      = res.data[WO-1:0];
    assign ovf       = res.ovf;
    assign unused_hi = res.data[FXP_MAXW-1:WO];

endmodule

// File: rtl/mac_accum_unsigned.sv
// Accumulates N_TERMS unsigned products per result and emits the sum in
// Q(WIO.WFO). Handshakes: a transfer happens on a cycle where valid & ready.
module mac_accum_unsigned
    import mac_accum_unsigned_pkg::*;
#(
    parameter int WI      = 2,
    parameter int WF      = 46,
    parameter int N_TERMS = 16,
    parameter int WIO     = 8,
    parameter int WFO     = 24
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   clr,
    input  logic [WI+WF-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIO+WFO-1:0]     out_data,
    output logic                   out_ovf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [clog2(N_TERMS)-1:0] term_cnt,
    output state_t                 dbg_state
);

    localparam int CW = clog2(N_TERMS);
    localparam int AW = WI + WF + CW;

    state_t                 state, state_nxt;
    logic [AW-1:0]          acc;
    logic [AW-1:0]          sum_nxt;
    logic [WIO+WFO-1:0]     fmt_data;
    logic                   fmt_ovf;
    logic                   beat;
    logic                   last;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign dbg_state = state;
    assign beat      = in_valid & in_ready;
    assign last      = (term_cnt == CW'(N_TERMS - 1));
    assign sum_nxt   = acc + AW'(in_data);

    fxp_resize_sat_unsigned #(
        .WII (WI + CW),
        .WIF (WF),
        .WOI (WIO),
        .WOF (WFO)
    ) u_resize (
        .din  (sum_nxt),
        .dout (fmt_data),
        .ovf  (fmt_ovf)
    );

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ACC;
        end else begin
            case (state)
                ACC:     if (beat && last) state_nxt = OUT;
                OUT:     if (out_ready)    state_nxt = ACC;
                default: state_nxt = ACC;
            endcase
        end
    end

    // The accumulator and counter are cleared on the closing beat, so they
    // already read zero while the result waits in OUT.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ACC;
            acc      <= '0;
            term_cnt <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                acc      <= '0;
                term_cnt <= '0;
            end else if (beat) begin
                if (last) begin
                    acc      <= '0;
                    term_cnt <= '0;
                    out_data <= fmt_data;
                    out_ovf  <= fmt_ovf;
                end else begin
                    acc      <= sum_nxt;
                    term_cnt <= term_cnt + CW'(1);
                end
            end
        end
    end

endmodule
